// File: rtl/seg7_pkg.sv
// seg7_pkg: source-select encodings, hex glyphs and digit count shared by the seven-segment debug monitor
package seg7_pkg;

    typedef enum logic [1:0] {
        SRC_STORE_DATA = 2'b00,
        SRC_STORE_ADDR = 2'b01,
        SRC_WB_RESULT  = 2'b10,
        SRC_STORE_CNT  = 2'b11
    } srcSel_t;

    localparam int DIGIT_COUNT = 8;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-high seven-segment glyph
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_debug_monitor.sv
// seg7_debug_monitor: captures pipeline write events and scans the selected 32-bit value onto an 8-digit display.
// Optional macro SEG7_BLANK_LEADING_ZERO_EN blanks digits above the most significant non-zero nibble.
module seg7_debug_monitor
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = DIGIT_COUNT,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write_i,
    input  logic [31:0] write_data_i,
    input  logic [31:0] alu_result_i,
    input  logic        reg_write_i,
    input  logic [31:0] result_i,
    input  logic [1:0]  src_sel_i,
    input  logic        freeze_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        capture_valid_o
);

    localparam logic [15:0] DIV_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [31:0] storeData, storeAddr, wbResult, storeCnt, selValue;
    logic        storeValid, wbValid, blankDigit, dpLit;
    logic [15:0] divCnt;
    logic [2:0]  digitIdx;
    logic [3:0]  nibble;
    logic [6:0]  glyph, segNext;
    logic [7:0]  anNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            storeData  <= '0;
            storeAddr  <= '0;
            wbResult   <= '0;
            storeCnt   <= '0;
            storeValid <= 1'b0;
            wbValid    <= 1'b0;
        end else if (!freeze_i) begin
            if (mem_write_i) begin
                storeData  <= write_data_i;
                storeAddr  <= alu_result_i;
                storeCnt   <= storeCnt + 32'd1;
                storeValid <= 1'b1;
            end
            if (reg_write_i) begin
                wbResult <= result_i;
                wbValid  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt   <= '0;
            digitIdx <= '0;
        end else if (divCnt == DIV_LAST) begin
            divCnt   <= '0;
            digitIdx <= (digitIdx == IDX_LAST) ? 3'd0 : digitIdx + 3'd1;
        end else begin
            divCnt <= divCnt + 16'd1;
        end
    end

    assign selValue = (src_sel_i == SRC_STORE_DATA) ? storeData :
                      (src_sel_i == SRC_STORE_ADDR) ? storeAddr :
                      (src_sel_i == SRC_WB_RESULT)  ? wbResult  : storeCnt;

    assign capture_valid_o = (src_sel_i == SRC_WB_RESULT) ? wbValid : storeValid;

    assign nibble = selValue[{digitIdx, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble(nibble),
        .glyph (glyph)
    );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    // A digit is leading-zero when it and every nibble above it are zero; digit 0 always shows
    assign blankDigit = (digitIdx != 3'd0) && ((selValue >> {digitIdx, 2'b00}) == 32'd0);
`else
    assign blankDigit = 1'b0;
`endif

    assign segNext = blankDigit ? SEG_BLANK : glyph;
    assign anNext  = 8'd1 << digitIdx;
    assign dpLit   = freeze_i && (digitIdx == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_o  <= {8{ACTIVE_LOW}};
            seg_o <= {7{ACTIVE_LOW}};
            dp_o  <= ACTIVE_LOW;
        end else begin
            an_o  <= anNext ^ {8{ACTIVE_LOW}};
            seg_o <= segNext ^ {7{ACTIVE_LOW}};
            dp_o  <= dpLit ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg7_debug_monitor.sv
// tb_seg7_debug_monitor: cycle model plus directed checks for seg7_debug_monitor (REFRESH_DIV=4, ACTIVE_LOW=1)
module tb_seg7_debug_monitor;

    localparam int RDIV = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] ZERO_ABOVE = 7'h7F;
`else
    localparam logic [6:0] ZERO_ABOVE = 7'h40;
`endif
    localparam logic [6:0] DEADBEEF_PINS [8] = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};

    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_write_i = 1'b0, reg_write_i = 1'b0, freeze_i = 1'b0;
    logic [31:0] write_data_i = '0, alu_result_i = '0, result_i = '0;
    logic [1:0]  src_sel_i = 2'b00;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        capture_valid_o;

    int nChecks = 0, nFails = 0;

    logic [31:0] mData = '0, mAddr = '0, mWb = '0, mCnt = '0;
    logic        mStV = 1'b0, mWbV = 1'b0, expOk = 1'b0, preloadReq = 1'b0;
    int          n = 0;
    logic [7:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;

    seg7_debug_monitor #(.REFRESH_DIV(RDIV), .NUM_DIGITS(8), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst),
        .mem_write_i(mem_write_i), .write_data_i(write_data_i), .alu_result_i(alu_result_i),
        .reg_write_i(reg_write_i), .result_i(result_i),
        .src_sel_i(src_sel_i), .freeze_i(freeze_i),
        .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .capture_valid_o(capture_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s);
        return (s == 2'd0) ? mData : (s == 2'd1) ? mAddr : (s == 2'd2) ? mWb : mCnt;
    endfunction

    // Pin pattern (active-low) for digit d of v, with optional leading-zero blanking
    function automatic logic [6:0] pinSeg(input logic [31:0] v, input int d);
        int msd = 0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) msd = i;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        if (d > msd) return 7'h7F;
`endif
        return ~GLYPH[v[4*d +: 4]];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            mData = '0; mAddr = '0; mWb = '0; mCnt = '0;
            mStV = 1'b0; mWbV = 1'b0; n = 0; expOk = 1'b0;
        end else begin
            if (preloadReq) mCnt = 32'hFFFF_FFFF;
            expAn  = ~(8'd1 << ((n / RDIV) % 8));
            expSeg = pinSeg(pick(src_sel_i), (n / RDIV) % 8);
            expDp  = !(((n / RDIV) % 8 == 7) && freeze_i);
            expOk  = 1'b1;
            n++;
            if (!freeze_i && mem_write_i) begin
                mData = write_data_i; mAddr = alu_result_i; mCnt = mCnt + 1; mStV = 1'b1;
            end
            if (!freeze_i && reg_write_i) begin
                mWb = result_i; mWbV = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("reset an", {24'd0, an_o}, 32'hFF);
            check("reset seg", {25'd0, seg_o}, 32'h7F);
            check("reset dp", {31'd0, dp_o}, 32'd1);
            check("reset valid", {31'd0, capture_valid_o}, 32'd0);
        end else if (expOk) begin
            check("model an", {24'd0, an_o}, {24'd0, expAn});
            check("model seg", {25'd0, seg_o}, {25'd0, expSeg});
            check("model dp", {31'd0, dp_o}, {31'd0, expDp});
            check("model valid", {31'd0, capture_valid_o},
                  {31'd0, (src_sel_i == 2'd2) ? mWbV : mStV});
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic waitDigit(input int d);
        logic [7:0] want;
        int k;
        want = ~(8'd1 << d);
        k = 0;
        tick(1);
        while (an_o !== want && k < 80) begin
            tick(1);
            k++;
        end
        check("reach digit", {24'd0, an_o}, {24'd0, want});
    endtask

    task automatic pulseStore(input logic [31:0] data, input logic [31:0] addr);
        mem_write_i = 1'b1; write_data_i = data; alu_result_i = addr;
        tick(1);
        mem_write_i = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(2);
        check("an in reset", {24'd0, an_o}, 32'hFF);
        rst = 1'b1;
        tick(1);
        check("first digit an", {24'd0, an_o}, 32'hFE);
        check("first digit seg", {25'd0, seg_o}, 32'h40);
        check("no capture valid", {31'd0, capture_valid_o}, 32'd0);
        tick(3);
        check("digit held 4 clocks", {24'd0, an_o}, 32'hFE);
        tick(1);
        check("digit 1 an", {24'd0, an_o}, 32'hFD);
        waitDigit(7);
        check("digit 7 an", {24'd0, an_o}, 32'h7F);
        waitDigit(0);
        check("wrap to digit 0", {24'd0, an_o}, 32'hFE);

        pulseStore(32'hDEAD_BEEF, 32'h0000_0010);
        for (int d = 0; d < 8; d++) begin
            waitDigit(d);
            check("store data digit", {25'd0, seg_o}, {25'd0, DEADBEEF_PINS[d]});
        end
        check("store valid", {31'd0, capture_valid_o}, 32'd1);
        src_sel_i = 2'b01;
        waitDigit(1);
        check("addr digit1", {25'd0, seg_o}, 32'h79);
        waitDigit(2);
        check("addr digit2", {25'd0, seg_o}, {25'd0, ZERO_ABOVE});
        waitDigit(0);
        check("addr digit0", {25'd0, seg_o}, 32'h40);

        src_sel_i = 2'b10;
        tick(1);
        check("wb not yet valid", {31'd0, capture_valid_o}, 32'd0);
        mem_write_i = 1'b1; reg_write_i = 1'b1; result_i = 32'h1234_5678;
        tick(1);
        mem_write_i = 1'b0; reg_write_i = 1'b0;
        check("wb valid", {31'd0, capture_valid_o}, 32'd1);
        waitDigit(7);
        check("wb digit7", {25'd0, seg_o}, 32'h79);
        waitDigit(0);
        check("wb digit0", {25'd0, seg_o}, 32'h00);
        src_sel_i = 2'b11;
        waitDigit(0);
        check("count 2", {25'd0, seg_o}, 32'h24);

        src_sel_i = 2'b00;
        freeze_i = 1'b1;
        for (int i = 0; i < 3; i++) pulseStore(32'h1111_1111, 32'h2222_2222);
        waitDigit(0);
        check("frozen data", {25'd0, seg_o}, 32'h0E);
        waitDigit(7);
        check("dp lit on digit 7", {31'd0, dp_o}, 32'd0);
        waitDigit(0);
        check("dp dark on digit 0", {31'd0, dp_o}, 32'd1);
        freeze_i = 1'b0;
        for (int i = 0; i < 2; i++) pulseStore(32'h1111_1111, 32'h2222_2222);
        src_sel_i = 2'b11;
        waitDigit(0);
        check("count 4", {25'd0, seg_o}, 32'h19);

        @(negedge clk);
        force dut.storeCnt = 32'hFFFF_FFFF;
        preloadReq = 1'b1;
        #1;
        release dut.storeCnt;
        tick(1);
        preloadReq = 1'b0;
        waitDigit(7);
        check("count preload digit7", {25'd0, seg_o}, 32'h0E);
        pulseStore(32'h0, 32'h0);
        waitDigit(0);
        check("count wrap digit0", {25'd0, seg_o}, 32'h40);

        src_sel_i = 2'b00;
        waitDigit(5);
        rst = 1'b0;
        #1;
        check("async an off", {24'd0, an_o}, 32'hFF);
        check("async seg off", {25'd0, seg_o}, 32'h7F);
        check("async dp off", {31'd0, dp_o}, 32'd1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("restart digit 0", {24'd0, an_o}, 32'hFE);
        check("holds cleared", {25'd0, seg_o}, 32'h40);
        check("valid cleared", {31'd0, capture_valid_o}, 32'd0);
        tick(4);
        check("restart digit 1", {24'd0, an_o}, 32'hFD);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
